// File: rtl/lsu_mem_access_if.sv
// ============================================================================
// Module : lsu_req_if, lsu_mem_if
// Brief  : Execute-side request/response bundle and doubleword memory port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        busy;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy, misalign
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy, misalign
    );
`else
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
`endif
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

`default_nettype wire

// File: rtl/lsu_mem_access.sv
// ============================================================================
// Module : lsu_mem_access
// Brief  : Load/store unit with RMW sub-doubleword stores and load extension.
//          Optional macro LSU_MISALIGN_TRAP_EN flags misaligned accesses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lsu_mem_access (
    input  logic      clk,
    input  logic      reset_n,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [2:0]  off_q;
    logic [63:0] wdata_q;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_q;
    logic        w_req_misaligned;
`endif

    logic        w_accept;
    logic        w_req_illegal;
    logic [2:0]  w_align_mask;
    logic [2:0]  w_req_off;
    logic [5:0]  w_shamt;
    logic [63:0] w_shifted;
    logic [63:0] w_load_ext;
    logic [63:0] w_lane_mask;
    logic [63:0] w_merge_mask;
    logic [63:0] w_merged;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_accept      = req.req_valid && (state_q == S_IDLE);
    assign w_req_illegal = req.req_we ? req.req_funct3[2] : (req.req_funct3 == 3'b111);

    always_comb begin
        w_align_mask = 3'b000;
        case (req.req_funct3[1:0])
            2'b00:   w_align_mask = 3'b000;
            2'b01:   w_align_mask = 3'b001;
            2'b10:   w_align_mask = 3'b011;
            default: w_align_mask = 3'b111;
        endcase
    end

    // Low offset bits below the access size are dropped so the lane never spills.
    assign w_req_off = req.req_addr[2:0] & ~w_align_mask;
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_req_misaligned = |(req.req_addr[2:0] & w_align_mask);
`endif

    // ------------------------------------------------------------------
    // Lane extraction and store merge
    // ------------------------------------------------------------------
    assign w_shamt   = {off_q, 3'b000};
    assign w_shifted = mem.mem_rdata >> w_shamt;

    always_comb begin
        w_load_ext = '0;
        case (funct3_q)
            3'b000:  w_load_ext = {{56{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load_ext = {{48{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_ext = {{32{w_shifted[31]}}, w_shifted[31:0]};
            3'b011:  w_load_ext = w_shifted;
            3'b100:  w_load_ext = {56'd0, w_shifted[7:0]};
            3'b101:  w_load_ext = {48'd0, w_shifted[15:0]};
            3'b110:  w_load_ext = {32'd0, w_shifted[31:0]};
            default: w_load_ext = '0;
        endcase
    end

    always_comb begin
        w_lane_mask = '1;
        case (funct3_q[1:0])
            2'b00:   w_lane_mask = 64'h0000_0000_0000_00FF;
            2'b01:   w_lane_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   w_lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: w_lane_mask = '1;
        endcase
    end

    assign w_merge_mask = w_lane_mask << w_shamt;
    assign w_merged     = (mem.mem_rdata & ~w_merge_mask) | ((wdata_q << w_shamt) & w_merge_mask);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_illegal) begin
                        state_d = S_RESP;
`ifdef LSU_MISALIGN_TRAP_EN
                    end else if (w_req_misaligned) begin
                        state_d = S_RESP;
`endif
                    end else if (req.req_we && (req.req_funct3[1:0] == 2'b11)) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (mem.mem_ack) begin
                    state_d = we_q ? S_WRITE : S_RESP;
                end
            end
            S_WRITE: begin
                if (mem.mem_ack) begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;

        if ((state_q == S_IDLE) && ((state_d == S_READ) || (state_d == S_WRITE))) begin
            mem_addr_d = {req.req_addr[63:3], 3'b000};
        end

        if ((state_q == S_IDLE) && (state_d == S_WRITE)) begin
            mem_wdata_d = req.req_wdata;
        end else if ((state_q == S_READ) && mem.mem_ack && we_q) begin
            mem_wdata_d = w_merged;
        end

        // Result changes only on entry to RESP so it holds between responses.
        if ((state_q == S_READ) && mem.mem_ack && !we_q) begin
            rsp_rdata_d = w_load_ext;
        end else if ((state_d == S_RESP) && (state_q != S_RESP)) begin
            rsp_rdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 3'b000;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                we_q       <= req.req_we;
                funct3_q   <= req.req_funct3;
                off_q      <= w_req_off;
                wdata_q    <= req.req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                misalign_q <= w_req_misaligned && !w_req_illegal;
`endif
            end
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req.req_ready = (state_q == S_IDLE);
        req.busy      = (state_q != S_IDLE);
        req.rsp_valid = (state_q == S_RESP);
        req.rsp_rdata = rsp_rdata_q;
        mem.mem_req   = (state_q == S_READ) || (state_q == S_WRITE);
        mem.mem_we    = (state_q == S_WRITE);
        mem.mem_addr  = mem_addr_q;
        mem.mem_wdata = mem_wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        req.misalign  = misalign_q && (state_q == S_RESP);
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_access.sv
// ============================================================================
// Module : tb_lsu_mem_access
// Brief  : Directed vector table, hand sequences and random accesses checked
//          against a byte-level memory model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem_access;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    lsu_req_if rq ();
    lsu_mem_if mb ();

    lsu_mem_access dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (rq.slave),
        .mem     (mb.master)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] dmem [16];
    logic [7:0]  bmem [128];
    int ack_delay = 0;
    int wait_cnt = 0;
    int n_writes = 0;
    int req_cycles = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_we  = 1'b0;
    logic [63:0] prev_addr = '0;
    logic [63:0] prev_wdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory responder: replies after ack_delay wait cycles, noisy ack while idle.
    always @(negedge clk) begin
        if (reset_n && mb.mem_req && prev_req && !prev_ack) begin
            chk("mem_we_stable",    {63'd0, mb.mem_we}, {63'd0, prev_we});
            chk("mem_addr_stable",  mb.mem_addr,  prev_addr);
            chk("mem_wdata_stable", mb.mem_wdata, prev_wdata);
        end
        if (!reset_n || !mb.mem_req) begin
            wait_cnt     = 0;
            mb.mem_ack   = 1'($urandom_range(0, 1));
            mb.mem_rdata = {$urandom, $urandom};
        end else if (wait_cnt >= ack_delay) begin
            chk("mem_addr_range", {63'd0, (mb.mem_addr[63:7] == 57'd2) && (mb.mem_addr[2:0] == 3'd0)}, 64'd1);
            mb.mem_ack   = 1'b1;
            mb.mem_rdata = dmem[mb.mem_addr[6:3]];
            if (mb.mem_we) begin
                dmem[mb.mem_addr[6:3]] = mb.mem_wdata;
                n_writes++;
            end
            wait_cnt = 0;
        end else begin
            mb.mem_ack = 1'b0;
            wait_cnt++;
        end
        if (reset_n && mb.mem_req) req_cycles++;
        prev_req   = reset_n && mb.mem_req;
        prev_ack   = mb.mem_ack;
        prev_we    = mb.mem_we;
        prev_addr  = mb.mem_addr;
        prev_wdata = mb.mem_wdata;
    end

    function automatic logic [63:0] model_dword(input int idx);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = bmem[idx*8 + i];
        return v;
    endfunction

    task automatic set_dword(input int idx, input logic [63:0] v);
        dmem[idx] = v;
        for (int i = 0; i < 8; i++) bmem[idx*8 + i] = v[8*i +: 8];
    endtask

    // Reference model: byte-addressed memory, size from funct3, latency from
    // the number of memory transactions and the wait cycles on each.
    task automatic model(input bit we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, input int d,
                         output logic [63:0] er, output int el, output bit em);
        int size, off, base;
        bit illegal, misal;
        size    = 1 << f3[1:0];
        off     = int'(addr[2:0]);
        base    = int'(addr - 64'h100) - off;
        illegal = we ? f3[2] : (f3 == 3'b111);
        misal   = (off % size) != 0;
        er = '0;
        em = 1'b0;
        el = 1;
        if (illegal) return;
`ifdef LSU_MISALIGN_TRAP_EN
        if (misal) begin
            em = 1'b1;
            return;
        end
`else
        off = off - (off % size);
`endif
        if (!we) begin
            for (int i = 0; i < size; i++) er |= 64'(bmem[base + off + i]) << (8*i);
            if (!f3[2] && size < 8 && er[8*size-1]) er |= {64{1'b1}} << (8*size);
            el = 2 + d;
        end else begin
            for (int i = 0; i < size; i++) bmem[base + off + i] = wd[8*i +: 8];
            el = (size == 8) ? 2 + d : 3 + 2*d;
        end
    endtask

    task automatic access(input bit we, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd,
                          output logic [63:0] rdata, output int lat, output bit mis);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!rq.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!rq.req_ready) chk("req_ready_timeout", 64'd0, 64'd1);
        rq.req_valid  = 1'b1;
        rq.req_we     = we;
        rq.req_funct3 = f3;
        rq.req_addr   = addr;
        rq.req_wdata  = wd;
        @(posedge clk);
        #1;
        rq.req_valid  = 1'b0;
        rq.req_we     = 1'($urandom_range(0, 1));
        rq.req_funct3 = 3'($urandom_range(0, 7));
        rq.req_addr   = {$urandom, $urandom};
        rq.req_wdata  = {$urandom, $urandom};
        lat   = -1;
        rdata = '0;
        mis   = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (rq.rsp_valid) begin
                lat   = k;
                rdata = rq.rsp_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
                mis   = rq.misalign;
`endif
                break;
            end
        end
        if (lat < 0) begin
            chk("rsp_timeout", 64'd0, 64'd1);
        end else begin
            @(negedge clk);
            chk("rsp_one_cycle", {63'd0, rq.rsp_valid}, 64'd0);
            chk("rsp_rdata_hold", rq.rsp_rdata, rdata);
        end
    endtask

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        int          exp_lat;
        bit          exp_mis;
        int          exp_wr;
        bit          chk_mem;
        logic [63:0] exp_mem;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [63:0] rd, er;
        int lat, el, w0, r0, d;
        bit mis, em, we, seen;
        logic [2:0]  f3;
        logic [63:0] addr, wd;

        rq.req_valid  = 1'b0;
        rq.req_we     = 1'b0;
        rq.req_funct3 = 3'b000;
        rq.req_addr   = '0;
        rq.req_wdata  = '0;
        mb.mem_ack    = 1'b0;
        mb.mem_rdata  = '0;
        for (int i = 0; i < 16; i++) set_dword(i, {$urandom, $urandom});
        set_dword(0, 64'h8877_6655_4433_2211);

        tbl[0]  = '{1'b0, 3'b000, 64'h107, 64'h0, 64'hFFFF_FFFF_FFFF_FF88, 2, 1'b0, 0, 1'b0, 64'h0};
        tbl[1]  = '{1'b0, 3'b100, 64'h107, 64'h0, 64'h0000_0000_0000_0088, 2, 1'b0, 0, 1'b0, 64'h0};
        tbl[2]  = '{1'b0, 3'b010, 64'h104, 64'h0, 64'hFFFF_FFFF_8877_6655, 2, 1'b0, 0, 1'b0, 64'h0};
        tbl[3]  = '{1'b0, 3'b110, 64'h104, 64'h0, 64'h0000_0000_8877_6655, 2, 1'b0, 0, 1'b0, 64'h0};
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[4]  = '{1'b0, 3'b010, 64'h102, 64'h0, 64'h0, 1, 1'b1, 0, 1'b0, 64'h0};
`else
        tbl[4]  = '{1'b0, 3'b010, 64'h102, 64'h0, 64'h0000_0000_4433_2211, 2, 1'b0, 0, 1'b0, 64'h0};
`endif
        tbl[5]  = '{1'b0, 3'b101, 64'h106, 64'h0, 64'h0000_0000_0000_8877, 2, 1'b0, 0, 1'b0, 64'h0};
        tbl[6]  = '{1'b1, 3'b001, 64'h102, 64'hABCD, 64'h0, 3, 1'b0, 1, 1'b1, 64'h8877_6655_ABCD_2211};
        tbl[7]  = '{1'b0, 3'b011, 64'h100, 64'h0, 64'h8877_6655_ABCD_2211, 2, 1'b0, 0, 1'b0, 64'h0};
        tbl[8]  = '{1'b0, 3'b001, 64'h102, 64'h0, 64'hFFFF_FFFF_FFFF_ABCD, 2, 1'b0, 0, 1'b0, 64'h0};
        tbl[9]  = '{1'b1, 3'b000, 64'h105, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0, 3, 1'b0, 1, 1'b1, 64'h8877_5A55_ABCD_2211};
        tbl[10] = '{1'b0, 3'b111, 64'h100, 64'h0, 64'h0, 1, 1'b0, 0, 1'b0, 64'h0};
        tbl[11] = '{1'b1, 3'b101, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 1'b0, 0, 1'b1, 64'h8877_5A55_ABCD_2211};
        tbl[12] = '{1'b0, 3'b011, 64'h100, 64'h0, 64'h8877_5A55_ABCD_2211, 2, 1'b0, 0, 1'b0, 64'h0};
        tbl[13] = '{1'b1, 3'b011, 64'h100, 64'h0123_4567_89AB_CDEF, 64'h0, 2, 1'b0, 1, 1'b1, 64'h0123_4567_89AB_CDEF};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {63'd0, rq.req_ready}, 64'd1);
        chk("rst_busy",      {63'd0, rq.busy},      64'd0);
        chk("rst_mem_req",   {63'd0, mb.mem_req},   64'd0);
        chk("rst_mem_we",    {63'd0, mb.mem_we},    64'd0);
        chk("rst_mem_addr",  mb.mem_addr,  64'd0);
        chk("rst_mem_wdata", mb.mem_wdata, 64'd0);
        chk("rst_rsp_valid", {63'd0, rq.rsp_valid}, 64'd0);
        chk("rst_rsp_rdata", rq.rsp_rdata, 64'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("rst_misalign",  {63'd0, rq.misalign},  64'd0);
`endif
        reset_n = 1'b1;

        // Directed vector table
        ack_delay = 0;
        for (int i = 0; i < 14; i++) begin
            w0 = n_writes;
            access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, rd, lat, mis);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
            chk($sformatf("vec%0d_misalign", i), {63'd0, mis}, {63'd0, tbl[i].exp_mis});
            chk($sformatf("vec%0d_writes", i), 64'(n_writes - w0), 64'(tbl[i].exp_wr));
            if (tbl[i].chk_mem) chk($sformatf("vec%0d_mem", i), dmem[0], tbl[i].exp_mem);
        end

        // sd with ack on the fourth request cycle
        ack_delay = 3;
        w0 = n_writes;
        r0 = req_cycles;
        access(1'b1, 3'b011, 64'h108, 64'h0123_4567_89AB_CDEF, rd, lat, mis);
        chk("sd_wait_latency", 64'(lat), 64'd5);
        chk("sd_wait_writes",  64'(n_writes - w0), 64'd1);
        chk("sd_wait_req_cycles", 64'(req_cycles - r0), 64'd4);
        chk("sd_wait_mem", dmem[1], 64'h0123_4567_89AB_CDEF);
        chk("sd_wait_rdata", rd, 64'd0);

        // Reset in the middle of a load
        ack_delay = 20;
        @(negedge clk);
        rq.req_valid  = 1'b1;
        rq.req_we     = 1'b0;
        rq.req_funct3 = 3'b011;
        rq.req_addr   = 64'h110;
        @(posedge clk);
        #1;
        rq.req_valid = 1'b0;
        @(negedge clk);
        chk("abort_mem_req_before", {63'd0, mb.mem_req}, 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_mem_req_drop", {63'd0, mb.mem_req},   64'd0);
        chk("abort_req_ready",    {63'd0, rq.req_ready}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rq.rsp_valid) seen = 1'b1;
        end
        chk("abort_no_rsp", {63'd0, seen}, 64'd0);
        chk("abort_ready_after", {63'd0, rq.req_ready}, 64'd1);

        // Random accesses against the byte-level model
        for (int i = 0; i < 16; i++) set_dword(i, {$urandom, $urandom});
        for (int n = 0; n < 150; n++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = 64'h100 + 64'($urandom_range(0, 127));
            wd   = {$urandom, $urandom};
            d    = $urandom_range(0, 2);
            ack_delay = d;
            model(we, f3, addr, wd, d, er, el, em);
            access(we, f3, addr, wd, rd, lat, mis);
            chk($sformatf("rnd%0d_rdata", n), rd, er);
            chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'(el));
            chk($sformatf("rnd%0d_misalign", n), {63'd0, mis}, {63'd0, em});
            chk($sformatf("rnd%0d_mem", n), dmem[addr[6:3]], model_dword(int'(addr[6:3])));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/lsu_mem_access.md
# lsu_mem_access

Load/store access unit between the execute stage and the doubleword-wide data memory of the RISC-V core. It accepts one load or store per handshake and runs a request/acknowledge transaction on the memory port. It performs read-modify-write for sub-doubleword stores. For loads, it extracts and sign/zero-extends the addressed lane and delivers the final 64-bit value to the writeback selector's memory-data input.

## Interface
Parameters:
- none; data and address widths are fixed at 64 bits.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  execute stage presents an access.
- `req_ready`  out  1  unit can accept an access.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 of the access.
- `req_addr`  in  64  byte address (rs1 + imm).
- `req_wdata`  in  64  store data (rs2).
- `mem_req`  out  1  memory transaction request.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  64  doubleword-aligned address, bits [2:0] = 0.
- `mem_wdata`  out  64  full doubleword to write.
- `mem_rdata`  in  64  doubleword read data, valid with `mem_ack`.
- `mem_ack`  in  1  memory completes the current transaction.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  64  extended load result; 0 for stores.
- `busy`  out  1  stall to pipeline; equals `!req_ready`.
- `misalign`  out  1  misaligned-access flag; present only with `LSU_MISALIGN_TRAP_EN`.

## Operation
- States: IDLE, READ, WRITE, RESP.
- In IDLE, `req_ready` = 1. An access is accepted on `req_valid && req_ready`. Then `req_we`, `req_funct3`, `req_addr` and `req_wdata` are latched, and offset = `req_addr[2:0]`.
- Load funct3 values: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
  - Load flow: IDLE→READ. On `mem_ack`, extract bits [8*offset +: size] little-endian. Sign-extend for lb/lh/lw; zero-extend for lbu/lhu/lwu. Then →RESP.
- Store funct3 values: 000 sb, 001 sh, 010 sw, 011 sd.
  - sd: IDLE→WRITE with `mem_wdata` = `req_wdata`.
  - sb/sh/sw: IDLE→READ. On `mem_ack`, merge the low size bytes of `req_wdata` into the read doubleword at offset. →WRITE with the merged word.
  - On the WRITE `mem_ack`: →RESP.
- Illegal funct3 (load 111, store 1xx): no memory transaction; IDLE→RESP with `rsp_rdata` = 0.
- RESP: `rsp_valid` = 1 for exactly one cycle, then →IDLE.
- Alignment without the macro: offset is forced to a multiple of size by clearing the low log2(size) bits. Accesses never cross a doubleword.

## Timing
- Reset values: state IDLE, `req_ready` = 1, `busy` = 0, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `misalign` = 0.
- `mem_req` is 1 throughout READ and WRITE. `mem_we`, `mem_addr` and `mem_wdata` stay stable until `mem_ack`.
- `mem_ack` is ignored when `mem_req` = 0. An ack is allowed in the first request cycle.
- Minimum latency, with accept at edge T and ack in the first cycle:
  - load / sd: `rsp_valid` in cycle T+2.
  - sb/sh/sw: `rsp_valid` in cycle T+3.
- Each extra wait cycle on `mem_ack` adds one cycle.
- `rsp_rdata` is updated when `rsp_valid` is asserted and holds until the next response.
- No new request is accepted in the RESP cycle. Back-to-back accesses are spaced at least one IDLE cycle apart.
- Reset asserted mid-transaction: `mem_req` drops asynchronously, and no `rsp_valid` is produced for the aborted access. A memory write in flight is abandoned.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - An access whose offset is not a multiple of its size is accepted but issues no memory transaction.
  - It goes IDLE→RESP with `rsp_valid` = 1, `misalign` = 1 (same cycle) and `rsp_rdata` = 0.
  - Memory contents are unchanged.
- Undefined: the `misalign` port is absent and low address bits are silently truncated as described in Operation.

## Test plan
- Memory dword at 0x100 = 0x8877_6655_4433_2211. Load lb @0x107 → `rsp_rdata` = 0xFFFF_FFFF_FFFF_FF88. Load lbu @0x107 → 0x0000_0000_0000_0088.
- Same dword. Load lw @0x104 → 0xFFFF_FFFF_8877_6655. Load lwu @0x104 → 0x0000_0000_8877_6655. With ack at first cycle, `rsp_valid` arrives 2 cycles after accept.
- Same dword. Store sh @0x102 with `req_wdata` = 0xABCD → read then write of 0x8877_6655_ABCD_2211. `rsp_valid` arrives 3 cycles after accept, `rsp_rdata` = 0.
- sd @0x108 = 0x0123_4567_89AB_CDEF with `mem_ack` delayed 4 cycles → exactly one write. `mem_req` is held 4 cycles, then `rsp_valid` for one cycle.
- Load ld issued, then `reset_n` pulled low while in READ → `mem_req` goes 0 immediately. After reset: `req_ready` = 1 and `rsp_valid` is never seen.
- Load lw @0x102:
  - with `LSU_MISALIGN_TRAP_EN` → no `mem_req`, and `rsp_valid` with `misalign` = 1 in cycle T+1.
  - without it → access at offset 0, result 0x0000_0000_4433_2211.
